// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the RN41 UART receive path.
package bt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned PHASE_W    = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_IDX_W  = 3;

  // Majority-vote sample phases within one bit; the decision is taken at the last one.
  localparam logic [PHASE_W-1:0] VOTE_PH_A = PHASE_W'(7);
  localparam logic [PHASE_W-1:0] VOTE_PH_B = PHASE_W'(8);
  localparam logic [PHASE_W-1:0] VOTE_PH_C = PHASE_W'(9);

  // Rounded clocks-per-tick divider, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bt_baud_tick.sv
// Free-running oversample tick generator with a synchronous restart.
module bt_baud_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIV-1, pulse tick on wrap; restart forces the count back to 0 without a tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 receiver for the RN41 link: synchroniser, 16x oversampling, 3-sample majority vote.
module bt_uart_rx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       recv_error
);

  import bt_uart_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(OVERSAMPLE - 1);

  logic [1:0]           sync_q, sync_d;
  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [1:0]           vote_q, vote_d;
  logic [BYTE_W-1:0]    rx_byte_q, rx_byte_d;
  logic                 received_q, received_d;
  logic                 recv_error_q, recv_error_d;
  logic                 is_receiving_q, is_receiving_d;
  logic                 restart_c;
  logic                 tick;
  logic                 vote_maj;

  bt_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart_c),
    .tick    (tick)
  );

  assign rxs    = sync_q[1];
  assign sync_d = {sync_q[0], rx};

  // Next-state, sampling and output strobes.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    vote_d       = vote_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    restart_c    = 1'b0;
    vote_maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          phase_d   = '0;
          restart_c = 1'b1;
        end
      end
      START, DATA, STOP: begin
        if (tick) begin
          phase_d = phase_q + PHASE_W'(1);
          if (phase_q == VOTE_PH_A) vote_d[0] = rxs;
          if (phase_q == VOTE_PH_B) vote_d[1] = rxs;
          if (phase_q == VOTE_PH_C) begin
            if (state_q == START) begin
              // A high vote means the falling edge was a glitch.
              if (vote_maj) begin
                state_d = IDLE;
              end else begin
                state_d   = DATA;
                bit_idx_d = '0;
              end
            end else if (state_q == DATA) begin
              shift_d   = {vote_maj, shift_q[BYTE_W-1:1]};
              bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
              if (bit_idx_q == BIT_IDX_W'(7)) state_d = STOP;
            end else begin
              // Re-arm right after the stop vote so back-to-back frames are caught.
              if (vote_maj) begin
                rx_byte_d  = shift_q;
                received_d = 1'b1;
                state_d    = IDLE;
              end else begin
                recv_error_d = 1'b1;
                state_d      = BREAK;
                phase_d      = '0;
              end
            end
          end
        end
      end
      BREAK: begin
        // Phase counter doubles as the consecutive-idle-tick counter here.
        if (tick) begin
          if (!rxs) begin
            phase_d = '0;
          end else if (phase_q == PH_LAST) begin
            state_d = IDLE;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    is_receiving_d = (state_d != IDLE);
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= 2'b11;
      state_q        <= IDLE;
      phase_q        <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      vote_q         <= '0;
      rx_byte_q      <= '0;
      received_q     <= 1'b0;
      recv_error_q   <= 1'b0;
      is_receiving_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      phase_q        <= phase_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      vote_q         <= vote_d;
      rx_byte_q      <= rx_byte_d;
      received_q     <= received_d;
      recv_error_q   <= recv_error_d;
      is_receiving_q <= is_receiving_d;
    end
  end

  assign received     = received_q;
  assign rx_byte      = rx_byte_q;
  assign recv_error   = recv_error_q;
  assign is_receiving = is_receiving_q;

endmodule

// File: tb/tb_bt_uart_rx.sv
// Scoreboard bench for bt_uart_rx at 7.3728 MHz / 115200 baud (DIV=4, 64 clk per bit).
module tb_bt_uart_rx;

  localparam int unsigned CLK_HZ = 7_372_800;
  localparam int unsigned BAUD   = 115200;
  localparam int BIT_T  = 640;   // 64 clk of 10 time units
  localparam int FAST_T = 627;   // ~2% fast line

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx = 1'b1;
  logic       received;
  logic       is_receiving;
  logic       recv_error;
  logic [7:0] rx_byte;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor event counters
  int n_rcv = 0;
  int n_err = 0;
  int n_overlap = 0;
  int n_busy = 0;
  int n_spur = 0;
  logic [7:0] prev_byte = 8'h00;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  bt_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .received     (received),
    .rx_byte      (rx_byte),
    .is_receiving (is_receiving),
    .recv_error   (recv_error)
  );

  always #5 clk = ~clk;

  // Observe DUT outputs on the falling edge and log events for the tests.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_byte <= rx_byte;
    end else begin
      if (received) begin
        n_rcv <= n_rcv + 1;
        got_q.push_back(rx_byte);
        if (is_receiving) n_busy <= n_busy + 1;
      end
      if (recv_error) n_err <= n_err + 1;
      if (received && recv_error) n_overlap <= n_overlap + 1;
      if (!received && (rx_byte !== prev_byte)) n_spur <= n_spur + 1;
      prev_byte <= rx_byte;
    end
  end

  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_val, input bit noise);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (noise) begin
        #357 rx = ~b[i];
        #36  rx = b[i];
        #(bit_t - 393);
      end else begin
        #(bit_t);
      end
    end
    rx = stop_val;
    #(bit_t);
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (received !== 1'b0) begin n_bad++; $display("FAIL reset_received got %b want 0", received); end
    n_cmp++; if (recv_error !== 1'b0) begin n_bad++; $display("FAIL reset_recv_error got %b want 0", recv_error); end
    n_cmp++; if (is_receiving !== 1'b0) begin n_bad++; $display("FAIL reset_is_receiving got %b want 0", is_receiving); end
    n_cmp++; if (rx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_frame;
    int r0, e0, b0;
    bit ok;
    logic [7:0] e, g;
    r0 = n_rcv; e0 = n_err; b0 = n_busy;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    send_frame(8'hA5, BIT_T, 1'b1, 1'b0);
    rx = 1'b1;
    wait_got(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL clean_timeout got %0d bytes want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL clean_byte got %h want %h", g, e); end
    end
    repeat (100) @(negedge clk);
    n_cmp++; if (n_rcv - r0 != 1) begin n_bad++; $display("FAIL clean_pulses got %0d want 1", n_rcv - r0); end
    n_cmp++; if (n_err != e0) begin n_bad++; $display("FAIL clean_errors got %0d want 0", n_err - e0); end
    n_cmp++; if (n_busy != b0) begin n_bad++; $display("FAIL clean_busy_in_pulse got %0d want 0", n_busy - b0); end
    n_cmp++; if (rx_byte !== 8'hA5) begin n_bad++; $display("FAIL clean_rx_byte got %h want a5", rx_byte); end
  endtask

  task automatic test_stop_error;
    int r0, e0;
    r0 = n_rcv; e0 = n_err;
    @(negedge clk);
    send_frame(8'h3C, BIT_T, 1'b0, 1'b0);
    rx = 1'b1;
    #560;
    n_cmp++; if (is_receiving !== 1'b1) begin n_bad++; $display("FAIL break_busy_early got %b want 1", is_receiving); end
    #240;
    n_cmp++; if (is_receiving !== 1'b0) begin n_bad++; $display("FAIL break_idle_late got %b want 0", is_receiving); end
    n_cmp++; if (n_err - e0 != 1) begin n_bad++; $display("FAIL break_err_pulses got %0d want 1", n_err - e0); end
    n_cmp++; if (n_rcv != r0) begin n_bad++; $display("FAIL break_rcv_pulses got %0d want 0", n_rcv - r0); end
    n_cmp++; if (rx_byte !== 8'hA5) begin n_bad++; $display("FAIL break_rx_byte got %h want a5", rx_byte); end
  endtask

  task automatic test_glitch;
    int r0, e0;
    r0 = n_rcv; e0 = n_err;
    @(negedge clk);
    rx = 1'b0;
    #120 rx = 1'b1;
    #30;
    n_cmp++; if (is_receiving !== 1'b1) begin n_bad++; $display("FAIL glitch_start got %b want 1", is_receiving); end
    #450;
    n_cmp++; if (is_receiving !== 1'b0) begin n_bad++; $display("FAIL glitch_idle got %b want 0", is_receiving); end
    repeat (200) @(negedge clk);
    n_cmp++; if (n_rcv != r0) begin n_bad++; $display("FAIL glitch_rcv got %0d want 0", n_rcv - r0); end
    n_cmp++; if (n_err != e0) begin n_bad++; $display("FAIL glitch_err got %0d want 0", n_err - e0); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] e, g;
    logic [7:0] bytes [3];
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      send_frame(bytes[i], FAST_T, 1'b1, 1'b0);
    end
    rx = 1'b1;
    wait_got(3, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL b2b_timeout got %0d bytes want 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL b2b_byte got %h want %h", g, e); end
    end
    repeat (50) @(negedge clk);
    n_cmp++; if (n_overlap != 0) begin n_bad++; $display("FAIL b2b_overlap got %0d want 0", n_overlap); end
  endtask

  task automatic test_reset_midframe;
    int r0;
    bit ok;
    logic [7:0] b, e, g;
    b = 8'h55;
    @(negedge clk);
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_T);
    end
    rx = b[4];
    #300;
    reset_n = 1'b0;
    #25;
    n_cmp++; if (received !== 1'b0) begin n_bad++; $display("FAIL midrst_received got %b want 0", received); end
    n_cmp++; if (is_receiving !== 1'b0) begin n_bad++; $display("FAIL midrst_is_receiving got %b want 0", is_receiving); end
    n_cmp++; if (rx_byte !== 8'h00) begin n_bad++; $display("FAIL midrst_rx_byte got %h want 00", rx_byte); end
    rx = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    r0 = n_rcv;
    repeat (1300) @(negedge clk);
    n_cmp++; if (n_rcv != r0) begin n_bad++; $display("FAIL midrst_stray_pulse got %0d want 0", n_rcv - r0); end
    n_cmp++; if (rx_byte !== 8'h00) begin n_bad++; $display("FAIL midrst_hold got %h want 00", rx_byte); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, BIT_T, 1'b1, 1'b0);
    rx = 1'b1;
    wait_got(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL midrst_timeout got %0d bytes want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL midrst_byte got %h want %h", g, e); end
    end
  endtask

  task automatic test_noise;
    int e0;
    bit ok;
    logic [7:0] e, g;
    e0 = n_err;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    send_frame(8'hC3, BIT_T, 1'b1, 1'b1);
    rx = 1'b1;
    wait_got(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL noise_timeout got %0d bytes want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL noise_byte got %h want %h", g, e); end
    end
    repeat (50) @(negedge clk);
    n_cmp++; if (rx_byte !== 8'hC3) begin n_bad++; $display("FAIL noise_rx_byte got %h want c3", rx_byte); end
    n_cmp++; if (n_err != e0) begin n_bad++; $display("FAIL noise_err got %0d want 0", n_err - e0); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_noise();
    n_cmp++; if (n_spur != 0) begin n_bad++; $display("FAIL rx_byte_unstrobed_change got %0d want 0", n_spur); end
    n_cmp++; if (n_overlap != 0) begin n_bad++; $display("FAIL strobe_overlap got %0d want 0", n_overlap); end
    n_cmp++; if (exp_q.size() != 0 || got_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover got exp=%0d got=%0d want 0/0", exp_q.size(), got_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
